riscv_lsu: RTL

- Multi-cycle load/store unit for the RV32I core. Sits between regfile read ports and data memory.
- Consumes rs1/rs2 read data plus decoded immediate, funct3 and rd. Drives a request/grant/rvalid memory interface.
- Produces the regfile write-back triple (wr_en, wr_addr, wr_data) for loads.

---
 rtl/riscv_lsu.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_lsu.sv
// riscv_lsu: multi-cycle RV32I load/store unit.
// Takes an address/data operand set from the issue stage, runs a
// request/grant/rvalid memory transaction and returns the extended load
// result as a one-cycle regfile write. Misaligned or illegal accesses are
// rejected with an error pulse and never reach memory. An optional
// response timeout aborts a load whose data never returns.
module riscv_lsu #(
  parameter int RSP_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic        lsu_is_store_i,
  input  logic [2:0]  lsu_funct3_i,
  input  logic [31:0] lsu_base_i,
  input  logic [31:0] lsu_imm_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [4:0]  lsu_rd_i,
  output logic        lsu_done_o,
  output logic        lsu_err_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        rf_wr_en_o,
  output logic [4:0]  rf_wr_addr_o,
  output logic [31:0] rf_wr_data_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Counter wide enough to hold RSP_TIMEOUT-1; CNT_LAST is the last WAIT
  // cycle that may still accept data before the load is abandoned.
  localparam int CW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (RSP_TIMEOUT > 0) ? CW'(RSP_TIMEOUT - 1) : '0;

  // Byte-lane mask for a 1/2/4-byte access at byte offset off.
  function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b0001 << off;
      2'd1:    be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Move store data from the low bits of rs2 into the addressed lane.
  function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [1:0] off,
                                             input logic [31:0] data);
    logic [31:0] res;
    case (size)
      2'd0:    res = {24'h00_0000, data[7:0]} << {off, 3'b000};
      2'd1:    res = {16'h0000, data[15:0]} << {off, 3'b000};
      default: res = data;
    endcase
    return res;
  endfunction

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'd0:    res = {{24{sh[7]}}, sh[7:0]};
      3'd1:    res = {{16{sh[15]}}, sh[15:0]};
      3'd4:    res = {24'h00_0000, sh[7:0]};
      3'd5:    res = {16'h0000, sh[15:0]};
      default: res = rdata;
    endcase
    return res;
  endfunction

  state_e        state_q, state_d;
  logic          is_store_q, is_store_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [31:0]   ea_q, ea_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [4:0]    rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          wr_en_q, wr_en_d;
  logic [4:0]    wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;

  logic [31:0]   ea_s;
  logic          legal_s;
  logic          misal_s;

  // Effective address and legality of the operation being offered.
  always_comb begin
    ea_s = lsu_base_i + lsu_imm_i;
    case (lsu_funct3_i)
      3'd0, 3'd1, 3'd2: legal_s = 1'b1;
      3'd4, 3'd5:       legal_s = ~lsu_is_store_i;
      default:          legal_s = 1'b0;
    endcase
    case (lsu_funct3_i[1:0])
      2'd1:    misal_s = ea_s[0];
      2'd2:    misal_s = (ea_s[1:0] != 2'b00);
      default: misal_s = 1'b0;
    endcase
  end

  // Next-state and next-output logic of the IDLE/REQ/WAIT sequencer.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    ea_d       = ea_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (lsu_valid_i) begin
          if (!legal_s || misal_s) begin
            err_d = 1'b1;
          end else begin
            is_store_d = lsu_is_store_i;
            funct3_d   = lsu_funct3_i;
            ea_d       = ea_s;
            be_d       = calc_be(lsu_funct3_i[1:0], ea_s[1:0]);
            wdata_d    = calc_wdata(lsu_funct3_i[1:0], ea_s[1:0], lsu_wdata_i);
            rd_d       = lsu_rd_i;
            state_d    = ST_REQ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_gnt_i) begin
          if (is_store_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          wr_en_d   = (rd_q != 5'd0);
          wr_addr_d = rd_q;
          wr_data_d = extract_load(funct3_q, ea_q[1:0], mem_rdata_i);
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else if (RSP_TIMEOUT > 0) begin
          if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, captured operation and registered pulse outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      ea_q       <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      be_q       <= 4'b0000;
      rd_q       <= 5'd0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 5'd0;
      wr_data_q  <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      ea_q       <= ea_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Memory-side fields are forced to zero outside REQ so idle outputs are quiet.
  assign lsu_ready_o  = (state_q == ST_IDLE);
  assign mem_req_o    = (state_q == ST_REQ);
  assign mem_addr_o   = mem_req_o ? {ea_q[31:2], 2'b00} : 32'h0000_0000;
  assign mem_we_o     = mem_req_o & is_store_q;
  assign mem_be_o     = mem_req_o ? be_q : 4'b0000;
  assign mem_wdata_o  = mem_req_o ? wdata_q : 32'h0000_0000;
  assign lsu_done_o   = done_q;
  assign lsu_err_o    = err_q;
  assign rf_wr_en_o   = wr_en_q;
  assign rf_wr_addr_o = wr_addr_q;
  assign rf_wr_data_o = wr_data_q;

endmodule
